// File: rtl/ddr3_avl_mem_responder_pkg.sv
// Shared types and constants for the DDR3 Avalon-MM memory responder.
package ddr3_avl_resp_pkg;

    localparam int AVL_AW  = 26;
    localparam int AVL_DW  = 64;
    localparam int AVL_BEW = 8;

    typedef enum logic {
        IDLE,
        WBURST
    } wr_state_t;

    typedef struct packed {
        logic [AVL_AW-1:0] addr;
        logic [1:0]        size;
    } rdq_entry_t;

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // A zero burst size is serviced as a single beat
    function automatic logic [1:0] eff_size(input logic [1:0] size);
        return (size == 2'd0) ? 2'd1 : size;
    endfunction

endpackage

// File: rtl/ddr3_avl_mem_responder_rdq.sv
// Read command queue: synchronous FIFO with full/empty flags and occupancy count.
module ddr3_avl_rdq
    import ddr3_avl_resp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  rdq_entry_t                 push_entry,
    input  logic                       pop,
    output rdq_entry_t                 head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    rdq_entry_t    slots [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/ddr3_avl_mem_responder.sv
// Avalon-MM responder standing in for the DDR3 controller, backed by an on-chip RAM.
// Optional random backpressure: define DDR3_AVL_RESP_RANDOM_STALL_EN.
module ddr3_avl_mem_responder
    import ddr3_avl_resp_pkg::*;
#(
    parameter int MEM_AW    = 10,
    parameter int RD_LAT    = 4,
    parameter int RDQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        avl_ready,
    input  logic [25:0] avl_addr,
    input  logic [1:0]  avl_size,
    input  logic [63:0] avl_wdata,
    input  logic [7:0]  avl_be,
    input  logic        avl_write_req,
    input  logic        avl_read_req,
    input  logic        avl_burstbegin,
    output logic [63:0] avl_rdata,
    output logic        avl_rdata_valid,
    output logic [15:0] err_count
);

    localparam int CW = $clog2(RDQ_DEPTH) + 1;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] inc);
        logic [16:0] sum;
        sum = {1'b0, a} + {14'b0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic              out_en;
    logic              stall;
    wr_state_t         state;
    wr_state_t         state_nxt;
    logic [MEM_AW-1:0] wr_base;
    logic [1:0]        wr_len;
    logic [1:0]        wr_beat;
    logic [1:0]        req_size;
    logic              wr_accept;
    logic              rd_accept;
    logic              wr_start;
    logic [MEM_AW-1:0] wr_addr;
    logic [2:0]        err_inc;

    rdq_entry_t        rdq_push_entry;
    rdq_entry_t        rdq_head;
    logic              rdq_full;
    logic              rdq_empty;
    logic [CW-1:0]     rdq_count;
    logic [CW-1:0]     inflight;
    logic              occ_full;
    logic [1:0]        rd_beat;
    logic              issue_vld;
    logic              issue_last;
    logic [MEM_AW-1:0] issue_addr;

    logic [AVL_DW-1:0] mem [2**MEM_AW];
    logic [AVL_DW-1:0] rdata_p0;
    logic              vld_p0;
    logic              last_p0;
    logic [AVL_DW-1:0] rdata_p1 [RD_LAT-1];
    logic              vld_p1   [RD_LAT-1];
    logic              last_p1  [RD_LAT-1];
    logic              out_vld;
    logic              out_last;

`ifdef DDR3_AVL_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!reset_n) lfsr <= LFSR_SEED;
        else          lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    assign stall = (lfsr[2:0] == 3'b000);
`else
    logic unused_lfsr_consts;
    assign unused_lfsr_consts = ^{LFSR_SEED, LFSR_TAPS};
    assign stall = 1'b0;
`endif

    // Commands still returning data count against the queue so a full queue
    // reflects every command whose burst has not fully left the responder.
    assign occ_full  = ((rdq_count + inflight) >= CW'(RDQ_DEPTH));
    assign avl_ready = out_en & ~rdq_full & ~occ_full & ~stall
                     & ~((state == WBURST) & avl_read_req);

    assign req_size  = eff_size(avl_size);
    assign wr_accept = avl_ready & avl_write_req;
    assign rd_accept = avl_ready & avl_read_req & ~avl_write_req;
    assign wr_start  = wr_accept & ((state == IDLE) | avl_burstbegin);
    assign wr_addr   = wr_start ? avl_addr[MEM_AW-1:0] : wr_base + MEM_AW'(wr_beat);

    always_comb begin
        state_nxt = state;
        if (wr_start)
            state_nxt = (req_size > 2'd1) ? WBURST : IDLE;
        else if (wr_accept && (wr_beat == wr_len - 2'd1))
            state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_en  <= 1'b0;
            state   <= IDLE;
            wr_beat <= '0;
        end else begin
            out_en <= 1'b1;
            state  <= state_nxt;
            if (wr_start)       wr_beat <= 2'd1;
            else if (wr_accept) wr_beat <= wr_beat + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_start) begin
            wr_base <= avl_addr[MEM_AW-1:0];
            wr_len  <= req_size;
        end
    end

    assign err_inc = 3'(wr_accept & (state == WBURST) & avl_burstbegin)
                   + 3'((state == WBURST) & avl_read_req)
                   + 3'((wr_start | rd_accept) & (avl_size == 2'd0))
                   + 3'(avl_ready & avl_read_req & avl_write_req);

    always_ff @(posedge clk) begin
        if (!reset_n) err_count <= '0;
        else          err_count <= sat_add(err_count, err_inc);
    end

    assign rdq_push_entry = '{addr: avl_addr, size: req_size};

    ddr3_avl_rdq #(
        .DEPTH (RDQ_DEPTH)
    ) u_rdq (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (rd_accept),
        .push_entry (rdq_push_entry),
        .pop        (issue_last & issue_vld),
        .head       (rdq_head),
        .full       (rdq_full),
        .empty      (rdq_empty),
        .count      (rdq_count)
    );

    // The head entry stays queued while its beats issue, one per cycle
    assign issue_vld  = ~rdq_empty;
    assign issue_last = (rd_beat == rdq_head.size - 2'd1);
    assign issue_addr = rdq_head.addr[MEM_AW-1:0] + MEM_AW'(rd_beat);

    always_ff @(posedge clk) begin
        if (!reset_n)       rd_beat <= '0;
        else if (issue_vld) rd_beat <= issue_last ? 2'd0 : rd_beat + 2'd1;
    end

    // Stage p0: RAM write at acceptance, registered read of the issued beat
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int i = 0; i < AVL_BEW; i++) begin
                if (avl_be[i]) mem[wr_addr][8*i +: 8] <= avl_wdata[8*i +: 8];
            end
        end
        rdata_p0 <= mem[issue_addr];
    end

    // Stage p1: delay line padding the read path out to RD_LAT
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            for (int i = 0; i < RD_LAT - 1; i++) begin
                vld_p1[i]  <= 1'b0;
                last_p1[i] <= 1'b0;
            end
        end else begin
            vld_p0     <= issue_vld;
            last_p0    <= issue_vld & issue_last;
            vld_p1[0]  <= vld_p0;
            last_p1[0] <= last_p0;
            for (int i = 1; i < RD_LAT - 1; i++) begin
                vld_p1[i]  <= vld_p1[i-1];
                last_p1[i] <= last_p1[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        rdata_p1[0] <= rdata_p0;
        for (int i = 1; i < RD_LAT - 1; i++) rdata_p1[i] <= rdata_p1[i-1];
    end

    assign out_vld         = vld_p1[RD_LAT-2];
    assign out_last        = last_p1[RD_LAT-2];
    assign avl_rdata_valid = out_vld;
    assign avl_rdata       = out_vld ? rdata_p1[RD_LAT-2] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inflight <= '0;
        end else begin
            case ({issue_vld & issue_last, out_vld & out_last})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: ;
            endcase
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{avl_addr[25:MEM_AW], rdq_head.addr[25:MEM_AW]};

endmodule
